// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write port plus registered read port, sync active-high reset.
// Define DATA_MEMORY_OOR_FLAG_EN to add a sticky oor_error output for out-of-range accesses.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] Write_data,
`ifdef DATA_MEMORY_OOR_FLAG_EN
  output logic [DATA_WIDTH-1:0] MemData_out,
  output logic                  oor_error
`else
  output logic [DATA_WIDTH-1:0] MemData_out
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic             wr_in_range;
  logic             rd_in_range;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_en;
  logic             same_addr_bypass;

  // Range is judged on the full address so high bits never alias into the array.
  assign wr_in_range      = (write_address < DEPTH_A);
  assign rd_in_range      = (read_address < DEPTH_A);
  assign wr_idx           = write_address[IDX_W-1:0];
  assign rd_idx           = read_address[IDX_W-1:0];
  assign wr_en            = MemWrite && wr_in_range;
  assign same_addr_bypass = wr_en && (write_address == read_address);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= Write_data;
    end
  end

  // Write-first on a same-address collision: the read sees the incoming data.
  always_ff @(posedge clk) begin
    if (reset) begin
      MemData_out <= '0;
    end else if (MemRead) begin
      if (!rd_in_range) begin
        MemData_out <= '0;
      end else if (same_addr_bypass) begin
        MemData_out <= Write_data;
      end else begin
        MemData_out <= mem[rd_idx];
      end
    end
  end

`ifdef DATA_MEMORY_OOR_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      oor_error <= 1'b0;
    end else if ((MemWrite && !wr_in_range) || (MemRead && !rd_in_range)) begin
      oor_error <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: reference array model feeding an expected-output queue.
module tb_data_memory;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;

  logic          clk;
  logic          reset;
  logic          MemWrite;
  logic          MemRead;
  logic [AW-1:0] write_address;
  logic [AW-1:0] read_address;
  logic [DW-1:0] Write_data;
  logic [DW-1:0] MemData_out;
`ifdef DATA_MEMORY_OOR_FLAG_EN
  logic          oor_error;
`endif

  data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .MemWrite      (MemWrite),
    .MemRead       (MemRead),
    .write_address (write_address),
    .read_address  (read_address),
    .Write_data    (Write_data),
`ifdef DATA_MEMORY_OOR_FLAG_EN
    .MemData_out   (MemData_out),
    .oor_error     (oor_error)
`else
    .MemData_out   (MemData_out)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_out;
  logic          model_oor;
  int            checks;
  int            errors;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic compare_output(input string tag);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, MemData_out, e);
    end
`ifdef DATA_MEMORY_OOR_FLAG_EN
    check({tag, "_oor"}, {31'd0, oor_error}, {31'd0, model_oor});
`endif
  endtask

  // driver: one clock cycle of traffic; model updated before the edge
  task automatic drive_cycle(input string tag, input logic we, input logic re,
                             input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                             input logic [DW-1:0] wd);
    @(negedge clk);
    reset         = 1'b0;
    MemWrite      = we;
    MemRead       = re;
    write_address = wa;
    read_address  = ra;
    Write_data    = wd;
    if (re) begin
      if (ra >= DEPTH) model_out = '0;
      else if (we && wa == ra) model_out = wd;
      else model_out = model_mem[ra[7:0]];
    end
    if ((we && wa >= DEPTH) || (re && ra >= DEPTH)) model_oor = 1'b1;
    if (we && wa < DEPTH) model_mem[wa[7:0]] = wd;
    exp_q.push_back(model_out);
    @(posedge clk);
    #1;
    compare_output(tag);
  endtask

  // reset with a write and a read asserted to show reset wins
  task automatic apply_reset(input int edges);
    for (int n = 0; n < edges; n++) begin
      @(negedge clk);
      reset         = 1'b1;
      MemWrite      = 1'b1;
      MemRead       = 1'b1;
      write_address = 32'd7;
      read_address  = 32'd7;
      Write_data    = 32'hDEAD_BEEF;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_out = '0;
      model_oor = 1'b0;
      exp_q.push_back(model_out);
      @(posedge clk);
      #1;
      compare_output("reset");
    end
    @(negedge clk);
    reset    = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    checks        = 0;
    errors        = 0;
    model_out     = '0;
    model_oor     = 1'b0;
    reset         = 1'b1;
    MemWrite      = 1'b0;
    MemRead       = 1'b0;
    write_address = '0;
    read_address  = '0;
    Write_data    = '0;

    apply_reset(2);

    // reset clears written data
    drive_cycle("wr7", 1'b1, 1'b0, 32'd7, 32'd0, 32'hA5A5_A5A5);
    drive_cycle("rd7_pre", 1'b0, 1'b1, 32'd0, 32'd7, 32'd0);
    apply_reset(2);
    drive_cycle("rd7_post_reset", 1'b0, 1'b1, 32'd0, 32'd7, 32'd0);

    // write then read with all-ones data
    drive_cycle("wr3", 1'b1, 1'b0, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive_cycle("rd3", 1'b0, 1'b1, 32'd0, 32'd3, 32'd0);

    // out-of-range read returns zero, flag sticks
    drive_cycle("rd_oor", 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF, 32'd0);
    drive_cycle("rd3_after_oor", 1'b0, 1'b1, 32'd0, 32'd3, 32'd0);
    drive_cycle("idle_after_oor", 1'b0, 1'b0, 32'd0, 32'd3, 32'd0);

    // same-address collision is write-first
    drive_cycle("rw_same5", 1'b1, 1'b1, 32'd5, 32'd5, 32'h1234_5678);
    drive_cycle("rd5", 1'b0, 1'b1, 32'd0, 32'd5, 32'd0);

    // different-address collision returns old contents
    drive_cycle("rw_diff", 1'b1, 1'b1, 32'd3, 32'd5, 32'h0BAD_F00D);
    drive_cycle("rd3_new", 1'b0, 1'b1, 32'd0, 32'd3, 32'd0);

    // hold with MemRead low
    drive_cycle("wr9", 1'b1, 1'b0, 32'd9, 32'd0, 32'hCAFE_BABE);
    drive_cycle("rd9", 1'b0, 1'b1, 32'd0, 32'd9, 32'd0);
    for (int i = 0; i < 5; i++) drive_cycle("hold", 1'b0, 1'b0, 32'd0, 32'd3, 32'd0);

    // out-of-range write is dropped, no aliasing onto 0
    drive_cycle("wr255", 1'b1, 1'b0, 32'd255, 32'd0, 32'h5555_AAAA);
    drive_cycle("wr256", 1'b1, 1'b0, 32'd256, 32'd0, 32'h1111_1111);
    drive_cycle("wr_hi_alias", 1'b1, 1'b0, 32'h0001_0000, 32'd0, 32'h2222_2222);
    drive_cycle("rd0", 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    drive_cycle("rd255", 1'b0, 1'b1, 32'd0, 32'd255, 32'd0);
    drive_cycle("rd256", 1'b0, 1'b1, 32'd0, 32'd256, 32'd0);

    // random traffic, mostly in range with occasional overshoot
    for (int i = 0; i < 400; i++) begin
      wa = AW'($urandom_range(0, 270));
      ra = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(0, 270)) : wa ^ AW'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ra = 32'hFFFF_FFFF;
      drive_cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  wa, ra, $urandom());
    end

    // reset again clears flag and memory
    apply_reset(1);
    drive_cycle("rd255_final", 1'b0, 1'b1, 32'd0, 32'd255, 32'd0);
    drive_cycle("rd9_final", 1'b0, 1'b1, 32'd0, 32'd9, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
